exp_pwm: RTL and testbench
==========================

# exp_pwm

Downstream consumer of the integrated exponential engine's 21-bit result. Each completed result is captured, scaled and saturated to an 8-bit duty cycle, then played out as a pulse-width-modulated signal. The PWM counter advances only on an external tick enable, so the adjustable frequency divider can set the PWM rate. Duty changes are double-buffered and take effect only at a period boundary, so no output period is ever truncated.

## Interface
- SHIFT, 10: right shift applied to `exp_in` before saturation.
- CNT_W, 8: counter and duty width; the period is 2^CNT_W ticks.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  counter advance enable (one-cycle pulse from the divider, or tied high).
- done  in  1  one-cycle strobe; `exp_in` is valid in that cycle.
- exp_in  in  21  unsigned exponential result.
- stop  in  1  return to IDLE and clear the counter.
- pwm  out  1  registered PWM output.
- duty  out  CNT_W  active duty value.
- pending  out  1  a new duty value is buffered and waiting for the period boundary.
- period_end  out  1  registered one-cycle pulse when the counter wraps.

## Operation
- Reset: state=IDLE; cnt, duty, shadow, pending, pwm and period_end all 0.
- Scaling: `sat = (exp_in >> SHIFT) > 2^CNT_W-1 ? 2^CNT_W-1 : (exp_in >> SHIFT)[CNT_W-1:0]`. With defaults, any of `exp_in[20:18]` set gives 255.
- States:
  - IDLE: pwm=0, cnt held at 0.
  - RUN: counting.
- IDLE --done--> RUN: `duty <= sat` immediately, `pending` stays 0, cnt=0.
- RUN, `done`: `shadow <= sat`, `pending <= 1`.
  - A later `done` before the boundary overwrites `shadow`; last value wins.
- RUN, `tick`: `cnt <= cnt+1`, wrapping from 2^CNT_W-1 to 0.
- Boundary = RUN && tick && cnt==2^CNT_W-1. At the boundary:
  - `period_end` pulses.
  - If `pending`: `duty <= shadow`, `pending <= 0`.
- `done` in the same cycle as the boundary bypasses the shadow: `duty <= sat` directly, `pending <= 0`.
- `stop` (any state) → IDLE, with cnt=0, pending=0, pwm=0. `duty` is retained.
  - `stop` has priority over `done` and `tick` in the same cycle.
- `rst` has priority over everything, including mid-period; outputs return to reset values on the next edge.
- `pwm <= (state==RUN) && (cnt < duty)`.
  - duty=0: pwm constantly low.
  - duty=255: high for 255 of 256 ticks.
- `tick` while IDLE is ignored.

## Timing
- `pwm` and `period_end` are registered: they reflect `cnt`/`duty`/state one clock after those registers update.
- `done` → new `duty` visible:
  - From IDLE: next edge.
  - From RUN: the edge of the next boundary.
- `pending` rises on the edge after `done` and falls on the boundary edge.
- Period = 2^CNT_W ticks. With `tick` tied high, that is 256 clocks.
- `done` and `stop` are single-cycle strobes. A held level re-captures every cycle; this is legal and harmless.

## Structure
- Shared package holds:
  - State encoding: IDLE=1'b0, RUN=1'b1.
  - Default constants CNT_W=8, SHIFT=10, EXP_W=21. The engine uses EXP_W as well.
- One sub-module, `pwm_counter`: the CNT_W-bit tick-enabled wrapping counter with clear input and registered wrap pulse.
- Capture, saturation, shadow buffer and FSM live in the top.

## Test plan
- Reset, then `done` with `exp_in`=21'h008000 → duty=32; with `tick` high, pwm high for exactly 32 of every 256 clocks.
- `exp_in`=21'h1FFFFF → duty=255, pwm low exactly 1 clock per period. `exp_in`=0 → pwm never high.
- In RUN at duty=32, `done` with 21'h010000 mid-period → `pending`=1, the current period finishes at 32; from the next period duty=64, `pending`=0.
- `done` on the exact boundary cycle with 21'h004000 → duty=16 from the next period, `pending` never asserts. Two `done` strobes within one period → only the second value is applied.
- `stop` asserted together with `done` → IDLE, pwm=0, `pending`=0, `duty` unchanged. `rst` mid-period → all outputs 0 next edge.
- `tick` pulsing every 4th clock, duty=128 → pwm high 512 clocks, low 512 clocks, `period_end` once per 1024 clocks.

Source files
------------

// File: rtl/exp_pwm_pkg.sv
// Shared definitions for the exponential-result PWM consumer.
package exp_pwm_pkg;

    // Width of the exponential engine's result bus. The engine uses it too.
    localparam int EXP_W     = 21;
    // Default counter/duty width. The period is 2^CNT_W ticks.
    localparam int DEF_CNT_W = 8;
    // Default right shift applied to the result before saturation.
    localparam int DEF_SHIFT = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage : exp_pwm_pkg

// File: rtl/exp_pwm_if.sv
// Control and status bundle between the exponential engine side and exp_pwm.
interface exp_pwm_if
    import exp_pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             tick;        // counter advance enable
    logic             done;        // exp_in valid strobe
    logic [EXP_W-1:0] exp_in;      // unsigned exponential result
    logic             stop;        // return to IDLE
    logic             pwm;         // registered PWM output
    logic [CNT_W-1:0] duty;        // active duty value
    logic             pending;     // shadow duty waiting for the boundary
    logic             period_end;  // one-cycle wrap pulse

    modport master (
        output tick, done, exp_in, stop,
        input  pwm, duty, pending, period_end
    );

    modport slave (
        input  tick, done, exp_in, stop,
        output pwm, duty, pending, period_end
    );
endinterface : exp_pwm_if

// File: rtl/exp_pwm_counter.sv
// Tick-enabled wrapping period counter with clear and registered wrap pulse.
module pwm_counter
    import exp_pwm_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,      // advance by one this cycle
    input  logic             clr,     // force to zero; wins over en
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_o,  // counter sits at its final value
    output logic             wrap_o   // registered pulse after a wrap
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    assign last_o = (cnt_q == '1);
    assign cnt_o  = cnt_q;
    assign wrap_o = wrap_q;

    // Next count and wrap flag; clear beats advance.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves it unassigned and no latch is inferred.
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d  = cnt_q + CNT_W'(1);
            wrap_d = last_o;
        end
    end

    // Counter and wrap pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end
endmodule : pwm_counter

// File: rtl/exp_pwm.sv
// Captures exponential results, saturates them to a duty cycle, double-buffers
// duty changes to period boundaries and plays out a registered PWM signal.
module exp_pwm
    import exp_pwm_pkg::*;
#(
    parameter int SHIFT = DEF_SHIFT,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic      clk,
    input logic      rst,
    exp_pwm_if.slave bus
);
    localparam logic [CNT_W-1:0] DUTY_MAX = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;

    logic [EXP_W-1:0] shifted;
    logic [CNT_W-1:0] sat;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last;
    logic             cnt_en;
    logic             wrap;
    logic             boundary;

    // The counter only runs in RUN; stop clears it in any state.
    assign cnt_en   = (state_q == RUN) && bus.tick;
    assign boundary = cnt_en && cnt_last && !bus.stop;

    pwm_counter #(.CNT_W(CNT_W)) u_counter (
        .clk    (clk),
        .rst    (rst),
        .en     (cnt_en),
        .clr    (bus.stop),
        .cnt_o  (cnt),
        .last_o (cnt_last),
        .wrap_o (wrap)
    );

    // Scale the incoming result and clamp it to the largest duty value.
    always_comb begin
        shifted = bus.exp_in >> SHIFT;
        if (shifted > EXP_W'(DUTY_MAX)) begin
            sat = DUTY_MAX;
        end else begin
            sat = shifted[CNT_W-1:0];
        end
    end

    // FSM, duty shadow buffer and PWM compare; stop outranks done and tick.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pwm_d     = (state_q == RUN) && (cnt < duty_q);
        if (bus.stop) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            pwm_d     = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.done) begin
                        state_d   = RUN;
                        duty_d    = sat;
                        pending_d = 1'b0;
                    end
                end
                RUN: begin
                    if (boundary && bus.done) begin
                        // A result landing on the boundary goes straight in.
                        duty_d    = sat;
                        pending_d = 1'b0;
                    end else if (bus.done) begin
                        // Last result before the boundary wins.
                        shadow_d  = sat;
                        pending_d = 1'b1;
                    end else if (boundary && pending_q) begin
                        duty_d    = shadow_q;
                        pending_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; duty is only cleared by reset, never by stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pwm_q     <= pwm_d;
        end
    end

    assign bus.pwm        = pwm_q;
    assign bus.duty       = duty_q;
    assign bus.pending    = pending_q;
    assign bus.period_end = wrap;
endmodule : exp_pwm

// File: tb/tb_exp_pwm.sv
// Directed bench for exp_pwm: a cycle model tracks the expected outputs every
// clock, and hand-computed duty/high-count expectations pin that model.
module tb_exp_pwm;
    localparam int PERIOD = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exp_pwm_if #(.CNT_W(8)) bus ();

    exp_pwm #(.SHIFT(10), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Duty is the result divided by 1024, clamped to 255.
    function automatic int model_sat(input int e);
        int s;
        s = e / 1024;
        return (s > 255) ? 255 : s;
    endfunction

    bit m_run     = 1'b0;
    int m_cnt     = 0;
    int m_duty    = 0;
    int m_shadow  = 0;
    bit m_pending = 1'b0;
    bit m_pwm     = 1'b0;
    bit m_pe      = 1'b0;

    wire m_wrap_now = m_run && bus.tick && (m_cnt == PERIOD - 1);

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 1'b0; m_cnt <= 0; m_duty <= 0; m_shadow <= 0;
            m_pending <= 1'b0; m_pwm <= 1'b0; m_pe <= 1'b0;
        end else if (bus.stop) begin
            m_run <= 1'b0; m_cnt <= 0; m_pending <= 1'b0;
            m_pwm <= 1'b0; m_pe <= 1'b0;
        end else begin
            m_pwm <= m_run && (m_cnt < m_duty);
            m_pe  <= m_wrap_now;
            if (m_run && bus.tick) m_cnt <= (m_cnt + 1) % PERIOD;
            if (!m_run) begin
                if (bus.done) begin
                    m_run  <= 1'b1;
                    m_duty <= model_sat(int'(bus.exp_in));
                end
            end else if (bus.done && m_wrap_now) begin
                m_duty    <= model_sat(int'(bus.exp_in));
                m_pending <= 1'b0;
            end else if (bus.done) begin
                m_shadow  <= model_sat(int'(bus.exp_in));
                m_pending <= 1'b1;
            end else if (m_wrap_now && m_pending) begin
                m_duty    <= m_shadow;
                m_pending <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_pwm",        32'(bus.pwm),        32'(m_pwm));
            check("cyc_duty",       32'(bus.duty),       32'(m_duty));
            check("cyc_pending",    32'(bus.pending),    32'(m_pending));
            check("cyc_period_end", 32'(bus.period_end), 32'(m_pe));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_done(input logic [20:0] e);
        bus.done   = 1'b1;
        bus.exp_in = e;
        @(negedge clk);
        bus.done   = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
    endtask

    // Samples the current negedge first, then n-1 more.
    task automatic measure(input int n, output int hi, output int pe);
        hi = 0;
        pe = 0;
        repeat (n) begin
            hi += int'(bus.pwm);
            pe += int'(bus.period_end);
            @(negedge clk);
        end
    endtask

    task automatic wait_pe(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (bus.period_end) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, pe, ph;
        bus.tick = 1'b0; bus.done = 1'b0; bus.stop = 1'b0; bus.exp_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;

        // Reset state.
        check("rst_duty",    32'(bus.duty),       32'd0);
        check("rst_pwm",     32'(bus.pwm),        32'd0);
        check("rst_pending", 32'(bus.pending),    32'd0);
        check("rst_pe",      32'(bus.period_end), 32'd0);
        rst = 1'b0;
        bus.tick = 1'b1;

        // 0x008000 >> 10 = 32: high 32 of 256 clocks.
        pulse_done(21'h008000);
        check("idle_done_duty", 32'(bus.duty), 32'd32);
        measure(PERIOD, hi, pe);
        check("hi_duty32", 32'(hi), 32'd32);

        // Saturated result: low exactly one clock per period.
        pulse_stop();
        pulse_done(21'h1FFFFF);
        check("sat_duty", 32'(bus.duty), 32'd255);
        measure(PERIOD, hi, pe);
        check("hi_duty255", 32'(hi), 32'd255);

        // Zero result: never high.
        pulse_stop();
        pulse_done(21'h000000);
        check("zero_duty", 32'(bus.duty), 32'd0);
        measure(PERIOD, hi, pe);
        check("hi_duty0", 32'(hi), 32'd0);

        // Mid-period update is buffered until the boundary.
        pulse_stop();
        pulse_done(21'h008000);
        repeat (100) @(negedge clk);
        pulse_done(21'h010000);
        check("mid_pending", 32'(bus.pending), 32'd1);
        check("mid_duty_held", 32'(bus.duty), 32'd32);
        wait_pe("pe_after_mid");
        check("boundary_duty64", 32'(bus.duty), 32'd64);
        check("boundary_pending0", 32'(bus.pending), 32'd0);
        measure(PERIOD, hi, pe);
        check("hi_duty64", 32'(hi), 32'd64);

        // Now at the period_end sample (count 0); 255 clocks later count is at its last value.
        repeat (PERIOD - 1) @(negedge clk);
        pulse_done(21'h004000);
        check("bypass_pe", 32'(bus.period_end), 32'd1);
        check("bypass_duty16", 32'(bus.duty), 32'd16);
        check("bypass_pending0", 32'(bus.pending), 32'd0);

        // Two results in one period: the second wins.
        repeat (20) @(negedge clk);
        pulse_done(21'h008000);
        repeat (20) @(negedge clk);
        pulse_done(21'h00C000);
        check("two_pending", 32'(bus.pending), 32'd1);
        wait_pe("pe_after_two");
        check("two_duty48", 32'(bus.duty), 32'd48);

        // stop together with done: IDLE, duty retained, pending dropped.
        repeat (30) @(negedge clk);
        pulse_done(21'h010000);
        check("pre_stop_pending", 32'(bus.pending), 32'd1);
        bus.stop = 1'b1; bus.done = 1'b1; bus.exp_in = 21'h1FFFFF;
        @(negedge clk);
        bus.stop = 1'b0; bus.done = 1'b0;
        check("stop_pwm", 32'(bus.pwm), 32'd0);
        check("stop_pending", 32'(bus.pending), 32'd0);
        check("stop_duty48", 32'(bus.duty), 32'd48);
        measure(40, hi, pe);
        check("idle_hi", 32'(hi), 32'd0);
        check("idle_pe", 32'(pe), 32'd0);

        // Reset mid-period with pwm high and an update pending.
        pulse_done(21'h008000);
        repeat (10) @(negedge clk);
        pulse_done(21'h010000);
        check("pre_rst_pwm", 32'(bus.pwm), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_duty", 32'(bus.duty), 32'd0);
        check("mid_rst_pwm", 32'(bus.pwm), 32'd0);
        check("mid_rst_pending", 32'(bus.pending), 32'd0);
        check("mid_rst_pe", 32'(bus.period_end), 32'd0);
        rst = 1'b0;

        // tick every 4th clock, 0x020000 >> 10 = 128: 512 high per 1024 clocks.
        ph = 0;
        bus.tick = 1'b0;
        pulse_done(21'h020000);
        repeat (4 * PERIOD) begin
            bus.tick = (ph == 0);
            ph = (ph + 1) % 4;
            @(negedge clk);
        end
        hi = 0;
        pe = 0;
        repeat (4 * PERIOD) begin
            hi += int'(bus.pwm);
            pe += int'(bus.period_end);
            bus.tick = (ph == 0);
            ph = (ph + 1) % 4;
            @(negedge clk);
        end
        check("div4_duty", 32'(bus.duty), 32'd128);
        check("div4_hi", 32'(hi), 32'd512);
        check("div4_pe", 32'(pe), 32'd1);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule : tb_exp_pwm
